// File: rtl/cbs_pkg.sv
// Shared definitions for the credit-based shaper gate: default widths,
// FSM state encoding and the saturating credit clamp.
package cbs_pkg;

  localparam int CBS_CREDIT_WIDTH = 32;
  localparam int CBS_SLOPE_WIDTH  = 16;
  localparam int CBS_CLAMP_WIDTH  = 64;

  typedef logic [0:0] cbs_state_t;

  localparam cbs_state_t ST_IDLE = 1'b0;
  localparam cbs_state_t ST_TX   = 1'b1;

  typedef logic signed [CBS_CLAMP_WIDTH-1:0] cbs_wide_t;

  // Wide enough for any credit width up to 62 bits, so one function serves
  // every instance; callers sign-extend in and truncate out.
  function automatic cbs_wide_t clamp_credit(input cbs_wide_t value,
                                             input cbs_wide_t lo,
                                             input cbs_wide_t hi);
    cbs_wide_t result;
    if (value < lo) begin
      result = lo;
    end else if (value > hi) begin
      result = hi;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/cbs_credit_calc.sv
// Combinational next-credit computation for the CBS gate: picks one slope
// rule per cycle from the current state and clamps to [lo_credit, hi_credit].
module cbs_credit_calc
  import cbs_pkg::*;
#(
  parameter int CREDIT_WIDTH = CBS_CREDIT_WIDTH,
  parameter int SLOPE_WIDTH  = CBS_SLOPE_WIDTH
) (
  input  logic                    state,
  input  logic                    output_side_ready,
  input  logic                    s_axis_tvalid,
  input  logic [CREDIT_WIDTH-1:0] credit,
  input  logic [SLOPE_WIDTH-1:0]  idle_slope,
  input  logic [SLOPE_WIDTH-1:0]  send_slope,
  input  logic [CREDIT_WIDTH-1:0] hi_credit,
  input  logic [CREDIT_WIDTH-1:0] lo_credit,
  output logic [CREDIT_WIDTH-1:0] credit_next
);

  logic signed [CREDIT_WIDTH-1:0] credit_s;
  logic signed [CREDIT_WIDTH-1:0] hi_s;
  logic signed [CREDIT_WIDTH-1:0] lo_s;
  logic signed [CREDIT_WIDTH:0]   cur_ext;
  logic signed [CREDIT_WIDTH:0]   idle_ext;
  logic signed [CREDIT_WIDTH:0]   send_ext;
  logic signed [CREDIT_WIDTH:0]   sum;
  logic                           credit_neg;
  logic                           credit_pos;

  assign credit_s   = credit;
  assign hi_s       = hi_credit;
  assign lo_s       = lo_credit;
  assign cur_ext    = (CREDIT_WIDTH+1)'(credit_s);
  assign idle_ext   = (CREDIT_WIDTH+1)'(idle_slope);
  assign send_ext   = (CREDIT_WIDTH+1)'(send_slope);
  assign credit_neg = credit[CREDIT_WIDTH-1];
  assign credit_pos = !credit_neg && (|credit);

  // Rules in priority order; the extra headroom bit means the raw sum can
  // never wrap before the clamp sees it.
  always_comb begin
    sum = cur_ext;
    if (state == ST_TX) begin
      if (output_side_ready) begin
        sum = cur_ext - send_ext;
      end else begin
        sum = cur_ext + idle_ext;
      end
    end else if (s_axis_tvalid || credit_neg) begin
      sum = cur_ext + idle_ext;
    end else if (credit_pos) begin
      sum = '0;
    end
  end

  assign credit_next = CREDIT_WIDTH'(clamp_credit(CBS_CLAMP_WIDTH'(sum),
                                                  CBS_CLAMP_WIDTH'(lo_s),
                                                  CBS_CLAMP_WIDTH'(hi_s)));

endmodule

// File: rtl/cbs_credit_gate.sv
// Credit-based shaper gate for one traffic class on an 8-bit AXI4-Stream;
// frames start only with non-negative credit. Optional stats: CBS_CREDIT_GATE_STATS_EN.
module cbs_credit_gate
  import cbs_pkg::*;
#(
  parameter int CREDIT_WIDTH = CBS_CREDIT_WIDTH,
  parameter int SLOPE_WIDTH  = CBS_SLOPE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    output_side_ready,
  input  logic [SLOPE_WIDTH-1:0]  idle_slope,
  input  logic [SLOPE_WIDTH-1:0]  send_slope,
  input  logic [CREDIT_WIDTH-1:0] hi_credit,
  input  logic [CREDIT_WIDTH-1:0] lo_credit,
  output logic [CREDIT_WIDTH-1:0] credit,
  output logic                    tx_active
`ifdef CBS_CREDIT_GATE_STATS_EN
  ,
  output logic [31:0]             frame_count,
  output logic [31:0]             block_cycles
`endif
);

  cbs_state_t              state;
  cbs_state_t              state_next;
  logic [CREDIT_WIDTH-1:0] credit_q;
  logic [CREDIT_WIDTH-1:0] credit_next;
  logic                    credit_neg;
  logic                    frame_end;

  assign credit_neg = credit_q[CREDIT_WIDTH-1];
  assign frame_end  = (state == ST_TX) && s_axis_tvalid && m_axis_tready && s_axis_tlast;

  cbs_credit_calc #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .SLOPE_WIDTH  (SLOPE_WIDTH)
  ) u_calc (
    .state             (state),
    .output_side_ready (output_side_ready),
    .s_axis_tvalid     (s_axis_tvalid),
    .credit            (credit_q),
    .idle_slope        (idle_slope),
    .send_slope        (send_slope),
    .hi_credit         (hi_credit),
    .lo_credit         (lo_credit),
    .credit_next       (credit_next)
  );

  // Entry uses the registered (pre-update) credit, so a frame waiting on
  // credit enters the cycle after credit reaches zero.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (s_axis_tvalid && !credit_neg) state_next = ST_TX;
      ST_TX:   if (frame_end) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      credit_q  <= '0;
      tx_active <= 1'b0;
    end else begin
      state     <= state_next;
      credit_q  <= credit_next;
      tx_active <= (state_next == ST_TX);
    end
  end

  assign credit        = credit_q;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tvalid = (state == ST_TX) && s_axis_tvalid;
  assign s_axis_tready = (state == ST_TX) && m_axis_tready;

`ifdef CBS_CREDIT_GATE_STATS_EN
  logic blocked;

  assign blocked = (state == ST_IDLE) && s_axis_tvalid && credit_neg;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count  <= '0;
      block_cycles <= '0;
    end else begin
      if (frame_end && (frame_count != '1)) begin
        frame_count <= frame_count + 32'd1;
      end
      if (blocked && (block_cycles != '1)) begin
        block_cycles <= block_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
